// File: rtl/pattern_scan_engine_pkg.sv
// Shared types and constants for the pattern scan coprocessor.
// States, default memory map and window geometry live here.
package pse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    WRITE,
    DONE
  } pse_state_t;

  localparam int unsigned MSG_BASE_DEF = 0;
  localparam int unsigned NBYTES_DEF   = 32;
  localparam int unsigned PAT_ADDR_DEF = 32;
  localparam int unsigned RES_ADDR_DEF = 33;

  localparam int PAT_W = 5;
  localparam int N_WIN = 4;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/pattern_scan_engine_if.sv
// Data-memory port shared between the CPU core and the scan engine.
// The engine drives it through the master modport; the memory is the slave.
interface pattern_scan_engine_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/pattern_scan_engine_window_match.sv
// Counts 5-bit pattern hits for one message byte: four windows inside the
// byte and four windows straddling the previous byte's low nibble.
module window_match
  import pse_pkg::*;
(
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       prev,
  input  logic [7:0]       b,
  input  logic             first,
  output logic [2:0]       n_in,
  output logic [2:0]       n_x
);

  logic [11:0] chain;
  logic [3:0]  hit_in;
  logic [3:0]  hit_x;

  assign chain = {prev, b};

  // Windows chain[k+4:k]: k=0..3 lie inside b, k=4..7 reach back into prev.
  always_comb begin
    hit_in = '0;
    hit_x  = '0;
    for (int k = 0; k < N_WIN; k++) begin
      hit_in[k] = (chain[k +: PAT_W] == pat);
      hit_x[k]  = !first && (chain[k + N_WIN +: PAT_W] == pat);
    end
  end

  assign n_in = popcount4(hit_in);
  assign n_x  = popcount4(hit_x);

endmodule

// File: rtl/pattern_scan_engine.sv
// Program-3 coprocessor: loads the pattern, scans the message byte by byte
// and writes the three match counts back through the shared memory port.
module pattern_scan_engine
  import pse_pkg::*;
#(
  parameter int unsigned MSG_BASE = MSG_BASE_DEF,
  parameter int unsigned NBYTES   = NBYTES_DEF,
  parameter int unsigned PAT_ADDR = PAT_ADDR_DEF,
  parameter int unsigned RES_ADDR = RES_ADDR_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  pattern_scan_engine_if.master mem
);

  pse_state_t       state;
  pse_state_t       state_nxt;
  logic [7:0]       idx;
  logic [7:0]       ctb;
  logic [7:0]       cto;
  logic [7:0]       cts;
  logic [PAT_W-1:0] pat;
  logic [3:0]       prev;
  logic [2:0]       n_in;
  logic [2:0]       n_x;
  logic             last_byte;
  logic             last_write;
  logic             accept;

  assign last_byte  = (idx == 8'(NBYTES - 1));
  assign last_write = (idx == 8'd2);
  assign accept     = ((state == IDLE) || (state == DONE)) && start;

  window_match u_window_match (
    .pat   (pat),
    .prev  (prev),
    .b     (mem.mem_rd_data),
    .first (idx == 8'd0),
    .n_in  (n_in),
    .n_x   (n_x)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       state_nxt = SCAN;
      SCAN:       if (last_byte) state_nxt = WRITE;
      WRITE:      if (last_write) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The index walks the message in SCAN, then is reused to sequence the writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      ctb  <= '0;
      cto  <= '0;
      cts  <= '0;
      pat  <= '0;
      prev <= '0;
    end else if (accept) begin
      idx  <= '0;
      ctb  <= '0;
      cto  <= '0;
      cts  <= '0;
      prev <= '0;
    end else begin
      unique case (state)
        LOAD: pat <= mem.mem_rd_data[7:3];
        SCAN: begin
          ctb  <= ctb + {5'b0, n_in};
          cto  <= cto + {7'b0, (n_in != 3'd0)};
          cts  <= cts + {5'b0, n_in} + {5'b0, n_x};
          prev <= mem.mem_rd_data[3:0];
          idx  <= last_byte ? 8'd0 : idx + 8'd1;
        end
        WRITE: idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = 1'b0;
    done            = (state == DONE);
    mem.mem_addr    = '0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_data = '0;
    unique case (state)
      LOAD: begin
        busy         = 1'b1;
        mem.mem_addr = 8'(PAT_ADDR);
      end
      SCAN: begin
        busy         = 1'b1;
        mem.mem_addr = 8'(MSG_BASE) + idx;
      end
      WRITE: begin
        busy          = 1'b1;
        mem.mem_addr  = 8'(RES_ADDR) + idx;
        mem.mem_wr_en = 1'b1;
        unique case (idx)
          8'd0:    mem.mem_wr_data = ctb;
          8'd1:    mem.mem_wr_data = cto;
          default: mem.mem_wr_data = cts;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: a behavioural memory plus a bit-string
// reference model of the three match counts.
module tb_pattern_scan_engine;

  logic clk;
  logic reset;
  logic start;
  logic done;
  logic busy;

  logic [7:0] mem [256];
  int errors;
  int checks;
  int wr_count;
  int idle_violations;

  pattern_scan_engine_if mif ();

  pattern_scan_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .busy  (busy),
    .mem   (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mif.mem_rd_data = mem[mif.mem_addr];

  always @(posedge clk) begin
    if (mif.mem_wr_en) begin
      mem[mif.mem_addr] = mif.mem_wr_data;
      wr_count++;
    end
  end

  always @(negedge clk) begin
    if (!busy && (mif.mem_addr != 8'd0 || mif.mem_wr_en || mif.mem_wr_data != 8'd0))
      idle_violations++;
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: treat the message as a 256-bit MSB-first string and slide a
  // 5-bit window over every start position; starts at bit offset 0..3 of a
  // byte stay inside that byte.
  task automatic model(output logic [7:0] e_ctb, output logic [7:0] e_cto, output logic [7:0] e_cts);
    logic [255:0] s;
    logic [4:0]   p;
    logic [4:0]   w;
    bit           hit [32];
    int           c_tb, c_to, c_ts;
    for (int i = 0; i < 32; i++) begin
      s[255 - 8*i -: 8] = mem[i];
      hit[i] = 1'b0;
    end
    p = mem[32][7:3];
    c_tb = 0; c_to = 0; c_ts = 0;
    for (int q = 0; q <= 251; q++) begin
      w = s[255 - q -: 5];
      if (w == p) begin
        c_ts++;
        if ((q % 8) <= 3) begin
          c_tb++;
          hit[q / 8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit[i]) c_to++;
    e_ctb = 8'(c_tb);
    e_cto = 8'(c_to);
    e_cts = 8'(c_ts);
  endtask

  task automatic fill_const(input logic [7:0] val, input logic [7:0] pat_byte);
    for (int i = 0; i < 32; i++) mem[i] = val;
    mem[32] = pat_byte;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[32] = 8'($urandom_range(0, 255));
  endtask

  // One full run from IDLE/DONE; optionally pulses start while busy.
  task automatic apply_stimulus(input string tag, input bit busy_starts);
    logic [7:0] e_ctb, e_cto, e_cts;
    int cyc;
    model(e_ctb, e_cto, e_cts);
    mem[33] = 8'hA5; mem[34] = 8'hA5; mem[35] = 8'hA5;
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_busy_after_start"}, {31'b0, busy}, 32'd1);
    check_output({tag, "_done_cleared"}, {31'b0, done}, 32'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      start = busy_starts && (cyc == 5 || cyc == 20);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check_output({tag, "_latency"}, cyc, 32'd36);
    check_output({tag, "_ctb"}, {24'b0, mem[33]}, {24'b0, e_ctb});
    check_output({tag, "_cto"}, {24'b0, mem[34]}, {24'b0, e_cto});
    check_output({tag, "_cts"}, {24'b0, mem[35]}, {24'b0, e_cts});
    check_output({tag, "_write_count"}, wr_count, 32'd3);
    check_output({tag, "_busy_low_in_done"}, {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_output({tag, "_done_held"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wr_count = 0;
    idle_violations = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_addr", {24'b0, mif.mem_addr}, 32'd0);
    check_output("reset_wr_en", {31'b0, mif.mem_wr_en}, 32'd0);
    check_output("reset_wr_data", {24'b0, mif.mem_wr_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    fill_const(8'h00, 8'h00);
    apply_stimulus("zeros", 1'b0);
    check_output("zeros_ctb_const", {24'b0, mem[33]}, 32'd128);
    check_output("zeros_cts_const", {24'b0, mem[35]}, 32'd252);

    fill_const(8'h55, 8'hA8);
    apply_stimulus("alt", 1'b0);
    check_output("alt_cts_const", {24'b0, mem[35]}, 32'd126);

    fill_const(8'h00, 8'hE0);
    mem[0] = 8'h07;
    apply_stimulus("cross", 1'b0);
    check_output("cross_cts_const", {24'b0, mem[35]}, 32'd1);

    fill_const(8'hFF, 8'h00);
    apply_stimulus("ff_pat0", 1'b0);
    fill_const(8'hFF, 8'hF8);
    apply_stimulus("ff_pat1", 1'b0);
    check_output("ff_pat1_cto_const", {24'b0, mem[34]}, 32'd32);

    // Reset in the middle of the scan must abandon the run without writing.
    fill_random();
    mem[33] = 8'h3C; mem[34] = 8'h3C; mem[35] = 8'h3C;
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("midreset_busy", {31'b0, busy}, 32'd0);
    check_output("midreset_done", {31'b0, done}, 32'd0);
    check_output("midreset_wr_en", {31'b0, mif.mem_wr_en}, 32'd0);
    check_output("midreset_addr", {24'b0, mif.mem_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_output("midreset_res0", {24'b0, mem[33]}, 32'h3C);
    check_output("midreset_res2", {24'b0, mem[35]}, 32'h3C);
    check_output("midreset_no_writes", wr_count, 32'd0);
    apply_stimulus("after_reset", 1'b0);

    fill_random();
    apply_stimulus("busy_starts", 1'b1);
    fill_random();
    apply_stimulus("restart_from_done", 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      if (r == 0) mem[32] = 8'h00;
      apply_stimulus($sformatf("rand%0d", r), 1'b0);
    end

    check_output("idle_port_quiet", idle_violations, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
